// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the bit-serial password link: the transmitter state
// encoding, the default password width and the code the lock accepts.
// No ports (package).
// -----------------------------------------------------------------------------
package lock_pkg;

    // Transmitter states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_RESP = 3'd2,
        GAP       = 3'd3,
        FIN       = 3'd4
    } tx_state_t;

    localparam int DEFAULT_PWD_WIDTH = 4;

    // Code the lock-side FSM unlocks on, sent MSB first.
    localparam logic [3:0] LOCK_CODE = 4'b1011;

endpackage

// File: rtl/pwd_shift_reg.sv
// -----------------------------------------------------------------------------
// pwd_shift_reg
// Parallel-load shift register that presents the password MSB first.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears the register)
//   load        - load din (takes priority over shift)
//   shift       - shift left by one, zero fill
//   din         - parallel password
//   msb         - current bit on the wire (register MSB)
// -----------------------------------------------------------------------------
module pwd_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] shift_r;

    // Password shift register: load, shift left, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r <= '0;
        end else if (load) begin
            shift_r <= din;
        end else if (shift) begin
            shift_r <= shift_r << 1;
        end else begin
            shift_r <= shift_r;
        end
    end

    assign msb = shift_r[WIDTH-1];

endmodule

// File: rtl/serial_pwd_transmitter.sv
// -----------------------------------------------------------------------------
// serial_pwd_transmitter
// Initiator side of the bit-serial password link. Shifts a captured password
// out MSB first, listens for the lock's unlock / pwd_incorrect response,
// retries on rejection or silence, and reports one pass/fail result per start.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start, pwd_in     - begin a transaction with this password (IDLE only)
//   busy, done        - transaction in progress / one-cycle end pulse
//   success           - result, held until the next accepted start
//   attempts_used     - attempts consumed, held until the next accepted start
//   serial_data/valid - offered bit and its qualifier
//   serial_ready      - lock accepts the offered bit
//   unlock            - lock response: correct password
//   pwd_incorrect     - lock response: wrong password (wins over unlock)
// -----------------------------------------------------------------------------
module serial_pwd_transmitter
    import lock_pkg::*;
#(
    parameter int PWD_WIDTH      = DEFAULT_PWD_WIDTH,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [PWD_WIDTH-1:0]              pwd_in,
    output logic                              busy,
    output logic                              done,
    output logic                              success,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_used,
    output logic                              serial_data,
    output logic                              serial_valid,
    input  logic                              serial_ready,
    input  logic                              unlock,
    input  logic                              pwd_incorrect
);

    localparam int AW = $clog2(MAX_ATTEMPTS+1);
    localparam int BW = $clog2(PWD_WIDTH+1);
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);

    localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_ATTEMPTS);
    localparam logic [AW-1:0] ATT_ONE  = AW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PWD_WIDTH-1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    tx_state_t            state_r;
    logic [PWD_WIDTH-1:0] pwd_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [TW-1:0]        tmo_r;

    logic                 listen_s;
    logic                 accept_s;
    logic                 resp_ok_s;
    logic                 tmo_hit_s;
    logic                 fail_s;
    logic                 load_s;
    logic [PWD_WIDTH-1:0] load_val_s;

    // Response decode, bit acceptance, timeout and shift-register load control.
    always_comb begin
        listen_s  = (state_r == SEND) || (state_r == WAIT_RESP);
        // Both responses together count as a rejection.
        resp_ok_s = listen_s && unlock && !pwd_incorrect;
        // A response in the same cycle wins over accepting the offered bit.
        accept_s  = (state_r == SEND) && serial_ready && !unlock && !pwd_incorrect;
        // Fires on the edge closing the TIMEOUT_CYCLES-th idle cycle.
        tmo_hit_s = listen_s && !unlock && !pwd_incorrect && !accept_s &&
                    (tmo_r >= TMO_LAST);
        fail_s    = (listen_s && pwd_incorrect) || tmo_hit_s;
        if (state_r == IDLE) begin
            load_s     = start;
            load_val_s = pwd_in;
        end else if (state_r == GAP) begin
            load_s     = 1'b1;
            load_val_s = pwd_r;
        end else begin
            load_s     = 1'b0;
            load_val_s = pwd_r;
        end
    end

    pwd_shift_reg #(
        .WIDTH (PWD_WIDTH)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .shift (accept_s),
        .din   (load_val_s),
        .msb   (serial_data)
    );

    // Transaction FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            pwd_r         <= '0;
            bit_cnt_r     <= '0;
            tmo_r         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            success       <= 1'b0;
            attempts_used <= '0;
            serial_valid  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        pwd_r         <= pwd_in;
                        attempts_used <= ATT_ONE;
                        success       <= 1'b0;
                        busy          <= 1'b1;
                        serial_valid  <= 1'b1;
                        bit_cnt_r     <= '0;
                        tmo_r         <= '0;
                        state_r       <= SEND;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND, WAIT_RESP: begin
                    if (resp_ok_s) begin
                        success      <= 1'b1;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        serial_valid <= 1'b0;
                        state_r      <= FIN;
                    end else if (fail_s) begin
                        serial_valid <= 1'b0;
                        tmo_r        <= '0;
                        if (attempts_used < ATT_MAX) begin
                            state_r <= GAP;
                        end else begin
                            success <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= FIN;
                        end
                    end else if (accept_s) begin
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        tmo_r     <= '0;
                        if (bit_cnt_r == BIT_LAST) begin
                            serial_valid <= 1'b0;
                            state_r      <= WAIT_RESP;
                        end else begin
                            state_r <= SEND;
                        end
                    end else begin
                        tmo_r <= (tmo_r == TMO_MAX) ? tmo_r : tmo_r + TMO_ONE;
                    end
                end
                GAP: begin
                    // One quiet cycle lets the lock return to idle before resending.
                    bit_cnt_r     <= '0;
                    tmo_r         <= '0;
                    attempts_used <= attempts_used + ATT_ONE;
                    serial_valid  <= 1'b1;
                    state_r       <= SEND;
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy         <= 1'b0;
                    serial_valid <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_pwd_transmitter.md
Name: serial_pwd_transmitter

Overview:
- Initiator side of the bit-serial password link: takes a parallel code word, shifts it out MSB-first on serial_data/serial_valid/serial_ready, and watches the lock's unlock/pwd_incorrect response.
- Retries on rejection up to a bounded attempt count, times out on a silent or stalled lock, and reports one pass/fail result per start.
- Sits between the host/keypad controller and the unlocking FSM.

Parameters:
- PWD_WIDTH, 4, number of password bits sent per attempt (>=1).
- MAX_ATTEMPTS, 3, total attempts per start, first send included (>=1).
- TIMEOUT_CYCLES, 16, idle cycles tolerated with no bit accepted and no response before the attempt counts as failed (>=2).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a transaction; sampled only in IDLE.
- pwd_in  input  PWD_WIDTH  password, captured on the accepted start cycle.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the transaction ends.
- success  output  1  valid with done; held until the next accepted start.
- attempts_used  output  $clog2(MAX_ATTEMPTS+1)  attempts consumed; held until the next start.
- serial_data  output  1  current bit = shift register MSB.
- serial_valid  output  1  bit offered.
- serial_ready  input  1  lock accepts the bit.
- unlock  input  1  lock response: password correct.
- pwd_incorrect  input  1  lock response: password wrong.

Behaviour:
- Reset: state IDLE; busy, done, success, serial_valid, serial_data and attempts_used are 0; shift register, bit counter and timeout counter are cleared. A reset mid-transaction drops serial_valid on the next edge with no done pulse.
- States:
  - IDLE: start=1 loads pwd_in into the shift register, sets attempts_used=1 and moves to SEND (serial_valid high on the next cycle). start in any other state is ignored.
  - SEND: serial_valid=1, serial_data=shift[MSB].
    - A bit is accepted when serial_valid&&serial_ready: shift left, bit_cnt++, timeout counter cleared.
    - After PWD_WIDTH accepted bits with no response, go to WAIT_RESP with serial_valid=0.
  - WAIT_RESP: serial_valid=0; waits for unlock or pwd_incorrect.
  - GAP: exactly one cycle with serial_valid=0, then reload the captured password, bit_cnt=0, attempts_used++, and enter SEND. This gives the lock a cycle to return to its idle state.
  - FIN: one cycle; done=1 and busy=0 in this cycle, then IDLE.
- Response sampling in SEND (any cycle with serial_valid=1) and in WAIT_RESP:
  - Responses are sampled regardless of serial_ready, because the lock drops ready in the cycle it responds.
  - unlock=1: success=1, go to FIN. The offered bit counts as consumed.
  - pwd_incorrect=1: if attempts_used < MAX_ATTEMPTS go to GAP, else success=0 and go to FIN.
  - unlock and pwd_incorrect both high in the same cycle is treated as pwd_incorrect.
  - A response has priority over bit acceptance in the same cycle.
- Timeout: the counter runs in SEND and WAIT_RESP and clears on every accepted bit and on every state entry. When it reaches TIMEOUT_CYCLES with no response, treat it as pwd_incorrect (retry or fail).
- Handshake rules: while serial_valid=1 and no response has arrived, serial_data and serial_valid stay stable until the bit is accepted.
- Latency: start to first serial_valid is 1 cycle. The final response to done is 1 cycle.
- Widths: bit_cnt is $clog2(PWD_WIDTH+1) bits; the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.

Decomposition:
- Shared package lock_pkg holds:
  - the tx state enum (IDLE, SEND, WAIT_RESP, GAP, FIN);
  - a default PWD_WIDTH constant;
  - the protocol constant for the lock code (4'b1011), also used by the lock-side FSM and the benches.
- One natural sub-module: pwd_shift_reg (parallel load, shift-left on enable, MSB output).
- Everything else stays in one flat FSM.

Test Plan:
- PWD_WIDTH=4, pwd_in=4'b1011 against the lock FSM with ready always 1 -> bits 1,0,1,1 on consecutive cycles; unlock on the 4th bit; done with success=1, attempts_used=1, 5 cycles after start.
- pwd_in=4'b1001, MAX_ATTEMPTS=3 -> pwd_incorrect on the 3rd bit of each attempt; GAP cycle of valid=0 between attempts; done with success=0, attempts_used=3.
- serial_ready held low 5 cycles on bit 2 -> serial_valid and serial_data stay stable and bit 3 is not sent early; the transaction still ends with unlock and success=1.
- Lock model that never responds or becomes ready, TIMEOUT_CYCLES=16 -> each attempt ends after 16 cycles; after 3 attempts done with success=0 and attempts_used=3.
- reset asserted during the 2nd bit of SEND -> next cycle serial_valid=0, busy=0, no done pulse; a new start afterwards sends the full password from the MSB.
- unlock and pwd_incorrect asserted together, and start pulsed while busy -> treated as incorrect (retry taken); the mid-transaction start has no effect on pwd or attempts_used.
